// File: rtl/layer_4_featuremap_streamer.sv
// Purpose : streams one IMG_SIZE x IMG_SIZE frame of packed 32-channel pixels from a
//           fixed-latency memory, in raster order.
// Latency : a read issued in cycle t appears on data_out/valid_out in cycle t+RD_LATENCY+1.
// Backpressure: hold stalls read issue only; reads already in flight still land on data_out.
//
// Ports:
//   Clk, Rst            rising-edge clock, synchronous active-high reset
//   start               one-cycle pulse, accepted only in IDLE
//   hold                stalls read issue while in RUN
//   mem_rd_en/mem_addr  read strobe and raster address (row*IMG_SIZE+col)
//   mem_rd_data         memory data, valid RD_LATENCY cycles after the strobe
//   data_out/valid_out  registered pixel, channel k at [32k+31:32k]
//   last_out            marks the final pixel of the frame
//   busy/done           frame in progress / one-cycle end-of-frame pulse
module layer_4_featuremap_streamer #(
  parameter int DATA_WIDTH = 32,
  parameter int CHANNELS   = 32,
  parameter int IMG_SIZE   = 104,
  parameter int ADDR_WIDTH = 14,
  parameter int RD_LATENCY = 1
) (
  input  logic                           Clk,
  input  logic                           Rst,
  input  logic                           start,
  input  logic                           hold,
  output logic                           mem_rd_en,
  output logic [ADDR_WIDTH-1:0]          mem_addr,
  input  logic [CHANNELS*DATA_WIDTH-1:0] mem_rd_data,
  output logic [CHANNELS*DATA_WIDTH-1:0] data_out,
  output logic                           valid_out,
  output logic                           last_out,
  output logic                           busy,
  output logic                           done
);

  localparam int CNT_W = $clog2(IMG_SIZE + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(IMG_SIZE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                          state_q;
  logic [CNT_W-1:0]                row_q;
  logic [CNT_W-1:0]                col_q;
  logic [ADDR_WIDTH-1:0]           mem_addr_q;
  logic                            mem_rd_en_q;
  logic [RD_LATENCY-1:0]           vld_pipe_q;
  logic [RD_LATENCY-1:0]           lst_pipe_q;
  logic [CHANNELS*DATA_WIDTH-1:0]  data_out_q;
  logic                            valid_out_q;
  logic                            last_out_q;
  logic                            busy_q;
  logic                            done_q;
  logic                            at_last_pix;

  // Row/col point at the pixel currently presented on mem_addr.
  assign at_last_pix = (row_q == CNT_MAX) && (col_q == CNT_MAX);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= IDLE;
      row_q       <= '0;
      col_q       <= '0;
      mem_addr_q  <= '0;
      mem_rd_en_q <= 1'b0;
      vld_pipe_q  <= '0;
      lst_pipe_q  <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      last_out_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // Valid/last flags travel alongside the memory read so they meet the data at the tail.
      vld_pipe_q[0] <= mem_rd_en_q;
      lst_pipe_q[0] <= mem_rd_en_q & at_last_pix;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_pipe_q[i] <= vld_pipe_q[i-1];
        lst_pipe_q[i] <= lst_pipe_q[i-1];
      end
      valid_out_q <= vld_pipe_q[RD_LATENCY-1];
      last_out_q  <= vld_pipe_q[RD_LATENCY-1] & lst_pipe_q[RD_LATENCY-1];
      if (vld_pipe_q[RD_LATENCY-1]) begin
        data_out_q <= mem_rd_data;
      end

      done_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= RUN;
            busy_q      <= 1'b1;
            mem_rd_en_q <= 1'b1;
            mem_addr_q  <= '0;
            row_q       <= '0;
            col_q       <= '0;
          end
        end
        RUN: begin
          if (mem_rd_en_q && at_last_pix) begin
            // Final read is on the bus this cycle; stop issuing.
            state_q     <= DRAIN;
            mem_rd_en_q <= 1'b0;
          end else begin
            // Counters advance only past a read that actually went out, so a hold
            // never skips or repeats an address.
            if (mem_rd_en_q) begin
              mem_addr_q <= mem_addr_q + ADDR_WIDTH'(1);
              if (col_q == CNT_MAX) begin
                col_q <= '0;
                row_q <= row_q + CNT_W'(1);
              end else begin
                col_q <= col_q + CNT_W'(1);
              end
            end
            mem_rd_en_q <= ~hold;
          end
        end
        DRAIN: begin
          if (vld_pipe_q == '0) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_rd_en = mem_rd_en_q;
  assign mem_addr  = mem_addr_q;
  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign last_out  = last_out_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_layer_4_featuremap_streamer.sv
module tb_layer_4_featuremap_streamer;
  localparam int DW   = 32;
  localparam int CH   = 32;
  localparam int BW   = DW * CH;
  localparam int AW   = 14;
  localparam int IMG  = 4;
  localparam int NPIX = IMG * IMG;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic Rst, start_a, hold_a, start_b, hold_b;
  logic          rd_a, vout_a, lout_a, busy_a, done_a;
  logic [AW-1:0] addr_a;
  logic [BW-1:0] rdat_a, dout_a;
  logic          rd_b, vout_b, lout_b, busy_b, done_b;
  logic [AW-1:0] addr_b;
  logic [BW-1:0] rdat_b, dout_b;

  layer_4_featuremap_streamer #(.DATA_WIDTH(DW), .CHANNELS(CH), .IMG_SIZE(IMG),
                                .ADDR_WIDTH(AW), .RD_LATENCY(1)) u_dut_a (
    .Clk(clk), .Rst(Rst), .start(start_a), .hold(hold_a),
    .mem_rd_en(rd_a), .mem_addr(addr_a), .mem_rd_data(rdat_a),
    .data_out(dout_a), .valid_out(vout_a), .last_out(lout_a),
    .busy(busy_a), .done(done_a));

  layer_4_featuremap_streamer #(.DATA_WIDTH(DW), .CHANNELS(CH), .IMG_SIZE(IMG),
                                .ADDR_WIDTH(AW), .RD_LATENCY(3)) u_dut_b (
    .Clk(clk), .Rst(Rst), .start(start_b), .hold(hold_b),
    .mem_rd_en(rd_b), .mem_addr(addr_b), .mem_rd_data(rdat_b),
    .data_out(dout_b), .valid_out(vout_b), .last_out(lout_b),
    .busy(busy_b), .done(done_b));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int t0 = 0;
  int mem_mode = 0;
  int n_tests = 0;
  int n_fail = 0;

  // Memory contents: mode 0 = address replicated in every channel, mode 1 = channel k holds 3F800000+k.
  function automatic logic [BW-1:0] word(input logic [AW-1:0] a, input int mode);
    logic [BW-1:0] w;
    for (int k = 0; k < CH; k++)
      w[32*k +: 32] = (mode == 0) ? {18'd0, a} : 32'h3F80_0000 + 32'(k);
    return w;
  endfunction

  // Memory models: data appears RD_LATENCY cycles after the strobe, garbage otherwise.
  logic [AW-1:0] ap_a;
  logic          ep_a = 1'b0;
  always @(posedge clk) begin
    ap_a <= addr_a;
    ep_a <= rd_a;
  end
  assign rdat_a = ep_a ? word(ap_a, mem_mode) : {CH{32'hDEAD_BEEF}};

  logic [AW-1:0] ap_b0, ap_b1, ap_b2;
  logic [2:0]    ep_b = 3'b000;
  always @(posedge clk) begin
    ap_b0 <= addr_b;
    ap_b1 <= ap_b0;
    ap_b2 <= ap_b1;
    ep_b  <= {ep_b[1:0], rd_b};
  end
  assign rdat_b = ep_b[2] ? word(ap_b2, mem_mode) : {CH{32'hDEAD_BEEF}};

  // Event logs, cycle numbers relative to the start cycle.
  logic [BW-1:0] qa_dat[$];
  int            qa_cyc[$];
  bit            qa_last[$];
  int            qa_done[$];
  int            qa_addr[$];
  int            qa_busy_fall = -1;
  bit            busy_a_prev = 1'b0;
  logic [BW-1:0] qb_dat[$];
  int            qb_cyc[$];
  int            qb_done[$];

  always @(negedge clk) begin
    if (vout_a) begin
      qa_dat.push_back(dout_a);
      qa_cyc.push_back(cyc - t0);
      qa_last.push_back(lout_a);
    end
    if (done_a) qa_done.push_back(cyc - t0);
    if (rd_a) qa_addr.push_back(int'(addr_a));
    if (busy_a_prev && !busy_a) qa_busy_fall = cyc - t0;
    busy_a_prev = busy_a;
    if (vout_b) begin
      qb_dat.push_back(dout_b);
      qb_cyc.push_back(cyc - t0);
    end
    if (done_b) qb_done.push_back(cyc - t0);
  end

  task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    int k;
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      k = 0;
      for (int i = CH - 1; i >= 0; i--)
        if (got[32*i +: 32] !== exp[32*i +: 32]) k = i;
      $display("FAIL %s: ch%0d got %h expected %h", tag, k, got[32*k +: 32], exp[32*k +: 32]);
    end
  endtask

  task automatic clear_logs();
    qa_dat.delete(); qa_cyc.delete(); qa_last.delete(); qa_done.delete(); qa_addr.delete();
    qb_dat.delete(); qb_cyc.delete(); qb_done.delete();
    qa_busy_fall = -1;
  endtask

  // Drives one frame on DUT A for ncyc cycles; hmask bit k = hold in cycle k,
  // restart_at/rst_at = cycle of an extra start pulse / reset pulse (-1 = none).
  task automatic run_a(input int mode, input logic [63:0] hmask, input int restart_at,
                       input int rst_at, input int ncyc);
    clear_logs();
    mem_mode = mode;
    @(posedge clk); #1;
    t0 = cyc;
    start_a = 1'b1;
    hold_a  = hmask[0];
    for (int k = 1; k < ncyc; k++) begin
      @(posedge clk); #1;
      start_a = (k == restart_at);
      hold_a  = hmask[k];
      Rst     = (k == rst_at);
      if (rst_at >= 0 && k == rst_at + 1) begin
        @(negedge clk);
        chk("rst_rd_en", BW'(rd_a), BW'(0));
        chk("rst_addr", BW'(addr_a), BW'(0));
        chk("rst_data", dout_a, '0);
        chk("rst_valid", BW'(vout_a), BW'(0));
        chk("rst_last", BW'(lout_a), BW'(0));
        chk("rst_busy", BW'(busy_a), BW'(0));
        chk("rst_done", BW'(done_a), BW'(0));
      end
    end
    start_a = 1'b0;
    hold_a  = 1'b0;
    Rst     = 1'b0;
  endtask

  // Full-frame checks on DUT A's logs.
  task automatic check_frame_a(input string tag, input int mode, input int first_cyc,
                               input int last_cyc, input int done_cyc);
    int n_last, lc, li;
    chk({tag, "_nvalid"}, BW'(qa_dat.size()), BW'(NPIX));
    chk({tag, "_nreads"}, BW'(qa_addr.size()), BW'(NPIX));
    for (int i = 0; i < qa_dat.size() && i < NPIX; i++)
      chk($sformatf("%s_pix%0d", tag, i), qa_dat[i], word(AW'(i), mode));
    for (int i = 0; i < qa_addr.size() && i < NPIX; i++)
      chk($sformatf("%s_addr%0d", tag, i), BW'(qa_addr[i]), BW'(i));
    if (qa_cyc.size() > 0) chk({tag, "_first_cyc"}, BW'(qa_cyc[0]), BW'(first_cyc));
    n_last = 0; lc = -1; li = -1;
    foreach (qa_last[i]) if (qa_last[i]) begin n_last++; lc = qa_cyc[i]; li = i; end
    chk({tag, "_nlast"}, BW'(n_last), BW'(1));
    chk({tag, "_last_cyc"}, BW'(lc), BW'(last_cyc));
    chk({tag, "_last_idx"}, BW'(li), BW'(NPIX - 1));
    chk({tag, "_ndone"}, BW'(qa_done.size()), BW'(1));
    if (qa_done.size() > 0) chk({tag, "_done_cyc"}, BW'(qa_done[0]), BW'(done_cyc));
    chk({tag, "_busy_fall"}, BW'(qa_busy_fall), BW'(done_cyc + 1));
  endtask

  initial begin
    int post;
    Rst = 1'b1; start_a = 1'b0; hold_a = 1'b0; start_b = 1'b0; hold_b = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rd_en", BW'(rd_a), BW'(0));
    chk("reset_addr", BW'(addr_a), BW'(0));
    chk("reset_data", dout_a, '0);
    chk("reset_valid", BW'(vout_a), BW'(0));
    chk("reset_last", BW'(lout_a), BW'(0));
    chk("reset_busy", BW'(busy_a), BW'(0));
    chk("reset_done", BW'(done_a), BW'(0));
    chk("reset_b_busy", BW'(busy_b), BW'(0));
    @(posedge clk); #1;
    Rst = 1'b0;

    // Plain frame: reads 1..16, valid 3..18, done 19, busy low from 20.
    run_a(0, 64'h0, -1, -1, 30);
    check_frame_a("base", 0, 3, 18, 19);

    // Channel packing.
    run_a(1, 64'h0, -1, -1, 30);
    check_frame_a("pack", 1, 3, 18, 19);

    // Hold in cycles 3,4,5 and 9: four lost read slots.
    run_a(0, 64'h238, -1, -1, 34);
    check_frame_a("hold", 0, 3, 22, 23);

    // Second start mid-frame is ignored.
    run_a(0, 64'h0, 6, -1, 30);
    check_frame_a("restart", 0, 3, 18, 19);

    // Reset mid-frame, then a clean frame.
    run_a(0, 64'h0, -1, 8, 20);
    post = 0;
    foreach (qa_cyc[i]) if (qa_cyc[i] >= 9) post++;
    chk("rst_stale_valid", BW'(post), BW'(0));
    chk("rst_no_done", BW'(qa_done.size()), BW'(0));
    run_a(0, 64'h0, -1, -1, 30);
    check_frame_a("post_rst", 0, 3, 18, 19);

    // RD_LATENCY=3: first valid in 5, done in 21.
    clear_logs();
    mem_mode = 0;
    @(posedge clk); #1;
    t0 = cyc;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("lat3_nvalid", BW'(qb_dat.size()), BW'(NPIX));
    if (qb_cyc.size() > 0) chk("lat3_first_cyc", BW'(qb_cyc[0]), BW'(5));
    for (int i = 0; i < qb_dat.size() && i < NPIX; i++)
      chk($sformatf("lat3_pix%0d", i), qb_dat[i], word(AW'(i), 0));
    chk("lat3_ndone", BW'(qb_done.size()), BW'(1));
    if (qb_done.size() > 0) chk("lat3_done_cyc", BW'(qb_done[0]), BW'(21));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
